// File: rtl/parity_frame_sequencer.sv
// parity_frame_sequencer: feeds a latched data word LSB-first through a
// bit-serial running-parity tracker, compares the result against the received
// parity bit, pulses done, and keeps a saturating count of failed frames.
module parity_frame_sequencer #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             par_in,
    input  logic             clr_err,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             running_par,
    output logic             done,
    output logic             parity_ok,
    output logic [CNT_W-1:0] err_count
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic             ODD_BIT  = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic             par_lat;
    logic [IDX_W-1:0] idx;
    logic             ok_reg;
    logic             ok_now;
    logic             accept;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        ser_valid  = 1'b0;
        ser_bit    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_bit   = shift_reg[0];
                if (idx == LAST_IDX) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Parity verdict: live compare during CHECK, registered copy otherwise.
    assign ok_now    = ~(running_par ^ par_lat ^ ODD_BIT);
    assign parity_ok = done ? ok_now : ok_reg;

    // Frame latch, serial shifter, bit index and running parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            par_lat     <= 1'b0;
            idx         <= '0;
            running_par <= 1'b0;
        end else if (accept) begin
            shift_reg   <= data_in;
            par_lat     <= par_in;
            idx         <= '0;
            running_par <= 1'b0;
        end else if (ser_valid) begin
            running_par <= running_par ^ shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            idx         <= idx + IDX_W'(1);
        end
    end

    // Held verdict and error counter; a clear beats a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_reg    <= 1'b0;
            err_count <= '0;
        end else begin
            if (done) begin
                ok_reg <= ok_now;
            end
            if (clr_err) begin
                err_count <= '0;
            end else if (done && !ok_now) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// Bench for parity_frame_sequencer: two instances (even parity / 8-bit count,
// odd parity / 2-bit count) share one stimulus stream and are compared every
// cycle against a frame-level reference model.
module tb_parity_frame_sequencer;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       par_in = 1'b0;
    logic       clr_err = 1'b0;

    logic       busy_a, ser_valid_a, ser_bit_a, running_par_a, done_a, parity_ok_a;
    logic [7:0] err_count_a;
    logic       busy_b, ser_valid_b, ser_bit_b, running_par_b, done_b, parity_ok_b;
    logic [1:0] err_count_b;

    always #5 clk = ~clk;

    parity_frame_sequencer #(.WIDTH(W), .ODD(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .par_in(par_in),
        .clr_err(clr_err), .busy(busy_a), .ser_valid(ser_valid_a), .ser_bit(ser_bit_a),
        .running_par(running_par_a), .done(done_a), .parity_ok(parity_ok_a),
        .err_count(err_count_a)
    );

    parity_frame_sequencer #(.WIDTH(W), .ODD(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .par_in(par_in),
        .clr_err(clr_err), .busy(busy_b), .ser_valid(ser_valid_b), .ser_bit(ser_bit_b),
        .running_par(running_par_b), .done(done_b), .parity_ok(parity_ok_b),
        .err_count(err_count_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a frame in flight is described by its data, its parity
    // bit and how many cycles it has been in flight (0..W-1 shifting, W checking).
    bit         m_active = 1'b0;
    int         m_phase = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_par = 1'b0;
    bit         m_ok [2] = '{1'b0, 1'b0};
    int         m_err [2] = '{0, 0};
    int         cfg_odd [2] = '{0, 1};
    int         cfg_max [2] = '{255, 3};

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       ok_a;
        logic       ok_b;
        logic       rpar;
        logic [7:0] err_a;
        logic [1:0] err_b;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit frame_ok(input int c);
        return ((($countones(m_data) + int'(m_par)) % 2) == cfg_odd[c]);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_phase  = 0;
        m_data   = 8'h00;
        m_par    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_ok[c]  = 1'b0;
            m_err[c] = 0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (m_active && m_phase == W) begin
                for (int c = 0; c < 2; c++) begin
                    m_ok[c] = frame_ok(c);
                    if (!m_ok[c] && m_err[c] < cfg_max[c]) m_err[c]++;
                end
                m_active = 1'b0;
            end else if (m_active) begin
                m_phase++;
            end else if (start) begin
                m_active = 1'b1;
                m_phase  = 0;
                m_data   = data_in;
                m_par    = par_in;
            end
            if (clr_err) begin
                for (int c = 0; c < 2; c++) m_err[c] = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit e_sv, e_sb, e_rp, e_done;
        e_sv   = m_active && (m_phase < W);
        e_sb   = e_sv ? m_data[m_phase] : 1'b0;
        e_rp   = ($countones(int'(m_data) & ((1 << m_phase) - 1)) % 2) == 1;
        e_done = m_active && (m_phase == W);
        check("a.busy", busy_a, m_active);
        check("a.ser_valid", ser_valid_a, e_sv);
        check("a.ser_bit", ser_bit_a, e_sb);
        check("a.running_par", running_par_a, e_rp);
        check("a.done", done_a, e_done);
        check("a.parity_ok", parity_ok_a, e_done ? frame_ok(0) : m_ok[0]);
        check("a.err_count", err_count_a, m_err[0]);
        check("b.busy", busy_b, m_active);
        check("b.ser_valid", ser_valid_b, e_sv);
        check("b.ser_bit", ser_bit_b, e_sb);
        check("b.running_par", running_par_b, e_rp);
        check("b.done", done_b, e_done);
        check("b.parity_ok", parity_ok_b, e_done ? frame_ok(1) : m_ok[1]);
        check("b.err_count", err_count_b, m_err[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Starts a frame and steps until the done cycle; reports edges from the
    // accepting edge to done, and the serial bits seen along the way.
    task automatic run_frame(input logic [7:0] d, input logic p, output int lat, output logic [7:0] bits);
        int k;
        start   = 1'b1;
        data_in = d;
        par_in  = p;
        step();
        start = 1'b0;
        lat   = 0;
        k     = 0;
        bits  = 8'h00;
        while (!done_a && lat < 20) begin
            if (ser_valid_a && k < 8) begin
                bits[k] = ser_bit_a;
                k++;
            end
            data_in = 8'($urandom);
            par_in  = 1'($urandom);
            step();
            lat++;
        end
    endtask

    initial begin
        int         lat;
        logic [7:0] bits;
        int         accepts [$];
        bit         prev_busy;
        int         sat_exp [5] = '{1, 2, 3, 3, 3};

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
        tbl[1] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 2'd2};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2};
        tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd3};
        tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd3};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 2'd3};
        tbl[7] = '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 2'd3};

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("reset.err_a", err_count_a, 0);
        check("reset.ok_a", parity_ok_a, 0);
        check("reset.busy_a", busy_a, 0);
        rst = 1'b0;
        step();

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].data, tbl[i].par, lat, bits);
            check("tbl.latency", lat, W);
            check("tbl.ser_bits", bits, tbl[i].data);
            check("tbl.ok_a", parity_ok_a, tbl[i].ok_a);
            check("tbl.ok_b", parity_ok_b, tbl[i].ok_b);
            check("tbl.rpar", running_par_a, tbl[i].rpar);
            step();
            check("tbl.err_a", err_count_a, tbl[i].err_a);
            check("tbl.err_b", err_count_b, tbl[i].err_b);
            check("tbl.held_ok_a", parity_ok_a, tbl[i].ok_a);
            check("tbl.held_rpar", running_par_a, tbl[i].rpar);
        end

        // Start held high: accepts spaced W+2 apart, every frame passes even parity
        start     = 1'b1;
        data_in   = 8'hFF;
        par_in    = 1'b0;
        prev_busy = 1'b0;
        for (int t = 0; t < 35; t++) begin
            step();
            if (busy_a && !prev_busy) accepts.push_back(t);
            if (done_a) check("hold.ok_a", parity_ok_a, 1);
            prev_busy = busy_a;
        end
        start = 1'b0;
        check("hold.accept_count", accepts.size(), 4);
        for (int i = 1; i < accepts.size(); i++) begin
            check("hold.interval", accepts[i] - accepts[i-1], W + 2);
        end
        step();
        step();

        // Saturation of the 2-bit counter, then clear colliding with a failing exit
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            run_frame(8'h00, 1'b0, lat, bits);
            check("sat.ok_b", parity_ok_b, 0);
            step();
            check("sat.err_b", err_count_b, sat_exp[i]);
        end
        run_frame(8'h00, 1'b0, lat, bits);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_wins.err_b", err_count_b, 0);

        // Asynchronous reset in the middle of a shift
        start   = 1'b1;
        data_in = 8'hA5;
        par_in  = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.busy", busy_a, 0);
        check("async_rst.ser_valid", ser_valid_a, 0);
        check("async_rst.ser_bit", ser_bit_a, 0);
        check("async_rst.running_par", running_par_a, 0);
        check("async_rst.done", done_a, 0);
        check("async_rst.parity_ok", parity_ok_a, 0);
        check("async_rst.err_b", err_count_b, 0);
        model_reset();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        run_frame(8'hA5, 1'b0, lat, bits);
        check("post_rst.latency", lat, W);
        check("post_rst.ok_a", parity_ok_a, 1);
        step();

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            start   = ($urandom_range(2) == 0);
            data_in = 8'($urandom);
            par_in  = 1'($urandom);
            clr_err = ($urandom_range(19) == 0);
            rst     = ($urandom_range(149) == 0);
            step();
        end
        start   = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
